// File: rtl/seq_radix4_mac_pkg.sv
// Shared constants and FSM encoding for the sequential radix-4 multiply-accumulate block.
package seq_radix4_mac_pkg;
  localparam int DEF_SIZE     = 16;
  localparam int DEF_ACC_SIZE = 40;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2
  } state_t;
endpackage

// File: rtl/radix4_pp_sel.sv
// Radix-4 digit selector: maps a 2-bit multiplier digit to 0, A, 2A or 3A.
module radix4_pp_sel #(
  parameter int SIZE = 16
) (
  input  logic [1:0]        digit,
  input  logic [2*SIZE-1:0] a,
  output logic [2*SIZE-1:0] partial
);
  always_comb begin
    partial = '0;
    unique case (digit)
      2'd0: partial = '0;
      2'd1: partial = a;
      2'd2: partial = a << 1;
      2'd3: partial = (a << 1) + a;
      default: partial = '0;
    endcase
  end
endmodule

// File: rtl/seq_radix4_mac.sv
// Sequential unsigned radix-4 multiplier feeding a wrapping accumulator with a sticky carry flag.
module seq_radix4_mac
  import seq_radix4_mac_pkg::*;
#(
  parameter int SIZE     = DEF_SIZE,
  parameter int ACC_SIZE = DEF_ACC_SIZE
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                iValid,
  output logic                oReady,
  input  logic [SIZE-1:0]     iA,
  input  logic [SIZE-1:0]     iB,
  input  logic                iClear,
  output logic [ACC_SIZE-1:0] oResult,
  output logic                oDone,
  output logic                oBusy,
  output logic                oOverflow
);
  localparam int        PW   = 2 * SIZE;
  localparam int        CW   = $clog2(SIZE / 2) > 0 ? $clog2(SIZE / 2) : 1;
  localparam logic [CW-1:0] LAST = CW'(SIZE / 2 - 1);

  state_t              state;
  logic [PW-1:0]       a_q, partial, pp;
  logic [SIZE-1:0]     b_q;
  logic [CW-1:0]       cnt;
  logic [ACC_SIZE-1:0] acc;
  logic [ACC_SIZE:0]   sum;

  // Multiplicand is pre-shifted by 2 each MUL cycle, so b_q[1:0] always holds digit k
  radix4_pp_sel #(.SIZE(SIZE)) u_sel (
    .digit   (b_q[1:0]),
    .a       (a_q),
    .partial (pp)
  );

  assign sum = {1'b0, acc} + {{(ACC_SIZE + 1 - PW){1'b0}}, partial};

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      partial   <= '0;
      cnt       <= '0;
      acc       <= '0;
      oDone     <= 1'b0;
      oOverflow <= 1'b0;
    end else begin
      oDone <= 1'b0;
      unique case (state)
        IDLE: begin
          if (iClear) begin
            acc       <= '0;
            oOverflow <= 1'b0;
          end
          if (iValid) begin
            a_q     <= {{SIZE{1'b0}}, iA};
            b_q     <= iB;
            partial <= '0;
            cnt     <= '0;
            state   <= MUL;
          end
        end
        MUL: begin
          partial <= partial + pp;
          a_q     <= a_q << 2;
          b_q     <= b_q >> 2;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) state <= ACC;
        end
        ACC: begin
          acc <= sum[ACC_SIZE-1:0];
          if (sum[ACC_SIZE]) oOverflow <= 1'b1;
          oDone <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign oReady  = (state == IDLE);
  assign oBusy   = (state == MUL) || (state == ACC);
  assign oResult = acc;
endmodule

// File: tb/tb_seq_radix4_mac.sv
// Directed bench for seq_radix4_mac; a 33-bit-accumulator twin shares all inputs for wrap checks.
module tb_seq_radix4_mac;
  logic        Clock = 1'b0;
  logic        Reset, iValid, iClear;
  logic [15:0] iA, iB;
  logic        oReady, oDone, oBusy, oOverflow;
  logic [39:0] oResult;
  logic        oReady33, oDone33, oBusy33, oOverflow33;
  logic [32:0] oResult33;

  int nchk = 0;
  int nerr = 0;

  seq_radix4_mac #(.SIZE(16), .ACC_SIZE(40)) u_dut (
    .Clock(Clock), .Reset(Reset), .iValid(iValid), .oReady(oReady), .iA(iA), .iB(iB),
    .iClear(iClear), .oResult(oResult), .oDone(oDone), .oBusy(oBusy), .oOverflow(oOverflow)
  );

  seq_radix4_mac #(.SIZE(16), .ACC_SIZE(33)) u_dut33 (
    .Clock(Clock), .Reset(Reset), .iValid(iValid), .oReady(oReady33), .iA(iA), .iB(iB),
    .iClear(iClear), .oResult(oResult33), .oDone(oDone33), .oBusy(oBusy33), .oOverflow(oOverflow33)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full transaction; poke keeps iValid/iClear high while busy to prove they are ignored
  task automatic run_mac(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input bit clr, input bit poke);
    int lat;
    bit seen;
    for (int i = 0; i < 20 && !oReady; i++) tick();
    chk({tag, "_ready"}, oReady, 1'b1);
    iValid = 1'b1; iA = a; iB = b; iClear = clr;
    tick();
    iValid = poke; iClear = poke; iA = 16'd9; iB = 16'd9;
    lat = 0; seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      lat++;
      if (poke && i == 0) begin
        chk({tag, "_rdy_busy"}, oReady, 1'b0);
        chk({tag, "_busy"}, oBusy, 1'b1);
      end
      if (oDone) begin
        seen = 1'b1;
        break;
      end
    end
    iValid = 1'b0; iClear = 1'b0;
    chk({tag, "_done"}, seen, 1'b1);
    chk({tag, "_lat"}, lat, 9);
  endtask

  initial begin
    int pulses;
    Reset = 1'b0; iValid = 1'b0; iClear = 1'b0; iA = '0; iB = '0;
    tick(); tick();
    chk("rst_ready", oReady, 1'b1);
    chk("rst_busy", oBusy, 1'b0);
    chk("rst_result", oResult, 40'd0);
    chk("rst_done", oDone, 1'b0);
    chk("rst_ovf", oOverflow, 1'b0);
    Reset = 1'b1;
    tick();

    run_mac("m3x5", 16'd3, 16'd5, 1'b0, 1'b0);
    chk("m3x5_res", oResult, 40'd15);
    chk("m3x5_ovf", oOverflow, 1'b0);
    tick();
    chk("done_low", oDone, 1'b0);

    run_mac("clrval", 16'd2, 16'd2, 1'b1, 1'b1);
    chk("clrval_res", oResult, 40'd4);

    iClear = 1'b1; tick(); iClear = 1'b0;
    chk("clr_res", oResult, 40'd0);
    run_mac("m7x3", 16'd7, 16'h0003, 1'b0, 1'b0);
    chk("m7x3_res", oResult, 40'd21);
    run_mac("mC000", 16'h1234, 16'hC000, 1'b0, 1'b0);
    chk("mC000_res", oResult, 40'h000DA70015);

    iClear = 1'b1; tick(); iClear = 1'b0;
    run_mac("ff1", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    chk("ff1_res", oResult, 40'h00FFFE0001);
    run_mac("ff2", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    chk("ff2_res", oResult, 40'h01FFFC0002);
    chk("ff2_ovf33", oOverflow33, 1'b0);
    run_mac("ff3", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    chk("ff3_res40", oResult, 40'h02FFFA0003);
    chk("ff3_ovf40", oOverflow, 1'b0);
    chk("ff3_res33", oResult33, 33'h0FFFA0003);
    chk("ff3_ovf33", oOverflow33, 1'b1);
    iClear = 1'b1; tick(); iClear = 1'b0;
    chk("clr_res33", oResult33, 33'd0);
    chk("clr_ovf33", oOverflow33, 1'b0);

    run_mac("pre_rst", 16'd3, 16'd5, 1'b0, 1'b0);
    chk("pre_rst_res", oResult, 40'd15);
    tick();
    iValid = 1'b1; iA = 16'd5; iB = 16'd5;
    tick();
    iValid = 1'b0;
    tick(); tick();
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    chk("midrst_busy", oBusy, 1'b0);
    chk("midrst_res", oResult, 40'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (oDone) pulses++;
      tick();
    end
    chk("midrst_nodone", pulses, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
